// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: both requester ports, the response
// channel and the data-memory port. The slave modport is the arbiter's
// view; the master modport is the requesters' and memory's view.
// Optional macro DMEM_ARB_LOCK_EN adds the per-requester lock_i signal.
interface dmem_port_arbiter_if;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [31:0] wdata0_i;
    logic [31:0] wdata1_i;
    logic [1:0]  num0_i;
    logic [1:0]  num1_i;
    logic        uns0_i;
    logic        uns1_i;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]  lock_i;
`endif
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic        rerr_o;
    logic [31:0] rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [1:0]  mem_num_o;
    logic        mem_uns_o;
    logic [31:0] mem_data_i;

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock_i,
`endif
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        input  num0_i, num1_i, uns0_i, uns1_i, mem_data_i,
        output gnt_o, rvalid_o, rerr_o, rdata_o,
        output mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
        output mem_num_o, mem_uns_o
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock_i,
`endif
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        output num0_i, num1_i, uns0_i, uns1_i, mem_data_i,
        input  gnt_o, rvalid_o, rerr_o, rdata_o,
        input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
        input  mem_num_o, mem_uns_o
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for the single data-memory port.
// Checks alignment/range, strobes the memory for one write cycle or RD_LAT
// read cycles, then returns a one-cycle response. All outputs registered.
// Optional macro DMEM_ARB_LOCK_EN: lock_i keeps the port with the current
// owner across transactions (atomic read-modify-write).
//
// state  | meaning
// IDLE   | waiting for an eligible request; grant and capture on that edge
// ACCESS | memory strobed from captured request; reads stay RD_LAT cycles
// ERRW   | illegal request, one filler cycle with no memory strobes
// RESP   | response computed; rvalid/rerr/rdata appear on the next cycle
module dmem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int RD_LAT    = 1
) (
    input logic              clk_i,
    input logic              rst_i,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ERRW = 2'd2, RESP = 2'd3} state_t;

    localparam logic [1:0]  NUM_WORD  = 2'b11;
    localparam logic [1:0]  NUM_HALF  = 2'b10;
    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);
    localparam logic [2:0]  CNT_INIT  = 3'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        ptr, owner;
    logic        cap_we, cap_uns, err;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_num;
    logic [2:0]  cnt;
`ifdef DMEM_ARB_LOCK_EN
    logic        locked;
`endif

    logic [1:0]  elig;
    logic        any_req, winner;
    logic        sel_we, sel_uns, sel_bad;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_num;
    logic [2:0]  sel_size;
    logic [32:0] sel_last;

    logic [1:0]  gnt_n, rvalid_n, mem_num_n;
    logic        rerr_n, mem_read_n, mem_write_n, mem_uns_n;
    logic [31:0] rdata_n, mem_addr_n, mem_data_n;
    logic [1:0]  gnt_q, rvalid_q, mem_num_q;
    logic        rerr_q, mem_read_q, mem_write_q, mem_uns_q;
    logic [31:0] rdata_q, mem_addr_q, mem_data_q;

    // Pick the winner and check the legality of its request.
    always_comb begin
        elig = bus.req_i;
`ifdef DMEM_ARB_LOCK_EN
        if (locked) elig = bus.req_i & (owner ? 2'b10 : 2'b01);
`endif
        any_req   = |elig;
        winner    = (elig == 2'b11) ? ptr : elig[1];
        sel_we    = winner ? bus.we_i[1] : bus.we_i[0];
        sel_addr  = winner ? bus.addr1_i : bus.addr0_i;
        sel_wdata = winner ? bus.wdata1_i : bus.wdata0_i;
        sel_num   = winner ? bus.num1_i : bus.num0_i;
        sel_uns   = winner ? bus.uns1_i : bus.uns0_i;
        case (sel_num)
            NUM_WORD: sel_size = 3'd4;
            NUM_HALF: sel_size = 3'd2;
            default:  sel_size = 3'd1;
        endcase
        // 33-bit end address so a request near 2^32 cannot wrap into range
        sel_last = {1'b0, sel_addr} + {30'd0, sel_size} - 33'd1;
        sel_bad  = (sel_num == 2'b00)
                 || (sel_num == NUM_WORD && sel_addr[1:0] != 2'b00)
                 || (sel_num == NUM_HALF && sel_addr[0])
                 || (sel_last > LAST_BYTE);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = sel_bad ? ERRW : ACCESS;
            ACCESS:  if (cap_we || cnt == 3'd0) state_nxt = RESP;
            ERRW:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; values take effect one cycle later through the output register.
    always_comb begin
        gnt_n = 2'b00;
        if (state == IDLE && any_req) gnt_n[winner] = 1'b1;
        rvalid_n = 2'b00;
        if (state == RESP) rvalid_n[owner] = 1'b1;
        rerr_n      = (state == RESP) && err;
        rdata_n     = (state == RESP && !cap_we && !err) ? bus.mem_data_i : 32'd0;
        mem_read_n  = (state == ACCESS) && !cap_we;
        mem_write_n = (state == ACCESS) && cap_we;
        mem_addr_n  = mem_addr_q;
        mem_num_n   = mem_num_q;
        mem_data_n  = mem_data_q;
        if (state == ACCESS) begin
            mem_addr_n = cap_addr;
            mem_num_n  = cap_num;
            if (cap_we) mem_data_n = cap_wdata;
        end
        mem_uns_n = cap_uns;
    end

    // Output register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rerr_q      <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_data_q  <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_num_q   <= 2'b00;
            mem_uns_q   <= 1'b0;
        end else begin
            gnt_q       <= gnt_n;
            rvalid_q    <= rvalid_n;
            rerr_q      <= rerr_n;
            rdata_q     <= rdata_n;
            mem_addr_q  <= mem_addr_n;
            mem_data_q  <= mem_data_n;
            mem_read_q  <= mem_read_n;
            mem_write_q <= mem_write_n;
            mem_num_q   <= mem_num_n;
            mem_uns_q   <= mem_uns_n;
        end
    end

    // Request capture, read-latency down-counter and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_num   <= 2'b00;
            cap_uns   <= 1'b0;
            err       <= 1'b0;
            cnt       <= 3'd0;
`ifdef DMEM_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && any_req) begin
                owner     <= winner;
                cap_we    <= sel_we;
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_num   <= sel_num;
                cap_uns   <= sel_uns;
                err       <= sel_bad;
                cnt       <= CNT_INIT;
            end
            if (state == ACCESS && cnt != 3'd0) cnt <= cnt - 3'd1;
            if (state == RESP) begin
`ifdef DMEM_ARB_LOCK_EN
                if (bus.lock_i[owner]) begin
                    locked <= 1'b1;
                end else begin
                    locked <= 1'b0;
                    ptr    <= ~owner;
                end
`else
                ptr <= ~owner;
`endif
            end
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.rerr_o      = rerr_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.mem_read_o  = mem_read_q;
    assign bus.mem_write_o = mem_write_q;
    assign bus.mem_num_o   = mem_num_q;
    assign bus.mem_uns_o   = mem_uns_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Instance u_dut1 (RD_LAT=1) sits on a
// byte-addressed memory model; u_dut4 (RD_LAT=4) sees a constant read value
// and is used for long-latency reads and reset in the middle of a read.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst1, rst4;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus1 ();
    dmem_port_arbiter_if bus4 ();

    dmem_port_arbiter #(.MEM_BYTES(1024), .RD_LAT(1)) u_dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));
    dmem_port_arbiter #(.MEM_BYTES(1024), .RD_LAT(4)) u_dut4 (.clk_i(clk), .rst_i(rst4), .bus(bus4));

`ifdef DMEM_ARB_LOCK_EN
    assign bus1.lock_i = 2'b00;
    assign bus4.lock_i = 2'b00;
`endif

    // Memory model: little-endian bytes, extension done by the memory.
    logic [7:0]  mem [0:1023];
    logic [9:0]  ma;
    logic [31:0] mrd;
    assign ma = bus1.mem_addr_o[9:0];

    always @(posedge clk) begin
        if (bus1.mem_write_o) begin
            case (bus1.mem_num_o)
                2'b11: begin
                    mem[ma]         <= bus1.mem_data_o[7:0];
                    mem[ma + 10'd1] <= bus1.mem_data_o[15:8];
                    mem[ma + 10'd2] <= bus1.mem_data_o[23:16];
                    mem[ma + 10'd3] <= bus1.mem_data_o[31:24];
                end
                2'b10: begin
                    mem[ma]         <= bus1.mem_data_o[7:0];
                    mem[ma + 10'd1] <= bus1.mem_data_o[15:8];
                end
                2'b01: mem[ma] <= bus1.mem_data_o[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        mrd = 32'd0;
        case (bus1.mem_num_o)
            2'b11: mrd = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
            2'b10: mrd = bus1.mem_uns_o ? {16'd0, mem[ma + 10'd1], mem[ma]}
                                        : {{16{mem[ma + 10'd1][7]}}, mem[ma + 10'd1], mem[ma]};
            2'b01: mrd = bus1.mem_uns_o ? {24'd0, mem[ma]} : {{24{mem[ma][7]}}, mem[ma]};
            default: mrd = 32'd0;
        endcase
    end

    assign bus1.mem_data_i = mrd;
    assign bus4.mem_data_i = 32'h1234_5678;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear1();
        bus1.req_i = 2'b00; bus1.we_i = 2'b00;
        bus1.addr0_i = 32'd0; bus1.addr1_i = 32'd0;
        bus1.wdata0_i = 32'd0; bus1.wdata1_i = 32'd0;
        bus1.num0_i = 2'b00; bus1.num1_i = 2'b00;
        bus1.uns0_i = 1'b0; bus1.uns1_i = 1'b0;
    endtask

    task automatic clear4();
        bus4.req_i = 2'b00; bus4.we_i = 2'b00;
        bus4.addr0_i = 32'd0; bus4.addr1_i = 32'd0;
        bus4.wdata0_i = 32'd0; bus4.wdata1_i = 32'd0;
        bus4.num0_i = 2'b11; bus4.num1_i = 2'b11;
        bus4.uns0_i = 1'b0; bus4.uns1_i = 1'b0;
    endtask

    task automatic load1(input bit r, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] num, input bit uns);
        if (r) begin
            bus1.we_i[1] = we; bus1.addr1_i = addr; bus1.wdata1_i = wdata;
            bus1.num1_i = num; bus1.uns1_i = uns;
        end else begin
            bus1.we_i[0] = we; bus1.addr0_i = addr; bus1.wdata0_i = wdata;
            bus1.num0_i = num; bus1.uns0_i = uns;
        end
    endtask

    // One complete transaction on u_dut1; inputs are scrambled after the grant.
    task automatic txn1(input string tag, input bit r, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] num, input bit uns,
                        input bit exp_err, input logic [31:0] exp_rdata);
        logic [1:0] oh;
        oh = r ? 2'b10 : 2'b01;
        load1(r, we, addr, wdata, num, uns);
        bus1.req_i = oh;
        tick();
        check({tag, ".gnt"}, 32'(bus1.gnt_o), 32'(oh));
        check({tag, ".early_rvalid"}, 32'(bus1.rvalid_o), 32'd0);
        bus1.req_i = 2'b00;
        bus1.addr0_i = 32'hFFFF_FFF0; bus1.addr1_i = 32'hFFFF_FFF0;
        bus1.wdata0_i = 32'h0BAD_0BAD; bus1.wdata1_i = 32'h0BAD_0BAD;
        tick();
        check({tag, ".mem_write"}, 32'(bus1.mem_write_o), 32'(we && !exp_err));
        check({tag, ".mem_read"}, 32'(bus1.mem_read_o), 32'(!we && !exp_err));
        check({tag, ".gnt_off"}, 32'(bus1.gnt_o), 32'd0);
        if (!exp_err) begin
            check({tag, ".mem_addr"}, bus1.mem_addr_o, addr);
            check({tag, ".mem_num"}, 32'(bus1.mem_num_o), 32'(num));
            if (we) check({tag, ".mem_data"}, bus1.mem_data_o, wdata);
            else    check({tag, ".mem_uns"}, 32'(bus1.mem_uns_o), 32'(uns));
        end
        tick();
        check({tag, ".rvalid"}, 32'(bus1.rvalid_o), 32'(oh));
        check({tag, ".rerr"}, 32'(bus1.rerr_o), 32'(exp_err));
        check({tag, ".rdata"}, bus1.rdata_o, exp_rdata);
        check({tag, ".strobes_off"}, 32'({bus1.mem_read_o, bus1.mem_write_o}), 32'd0);
    endtask

    initial begin
        rst1 = 1'b0; rst4 = 1'b0;
        clear1(); clear4();
        tick(); tick();
        check("rst.gnt", 32'(bus1.gnt_o), 32'd0);
        check("rst.rvalid", 32'(bus1.rvalid_o), 32'd0);
        check("rst.rerr", 32'(bus1.rerr_o), 32'd0);
        check("rst.rdata", bus1.rdata_o, 32'd0);
        check("rst.mem_addr", bus1.mem_addr_o, 32'd0);
        check("rst.mem_data", bus1.mem_data_o, 32'd0);
        check("rst.strobes", 32'({bus1.mem_read_o, bus1.mem_write_o}), 32'd0);
        check("rst.mem_num", 32'(bus1.mem_num_o), 32'd0);
        check("rst.mem_uns", 32'(bus1.mem_uns_o), 32'd0);
        check("rst4.outs", 32'({bus4.gnt_o, bus4.rvalid_o, bus4.mem_read_o}), 32'd0);
        rst1 = 1'b1; rst4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle.gnt", 32'(bus1.gnt_o), 32'd0);
            check("idle.rvalid", 32'(bus1.rvalid_o), 32'd0);
        end

        txn1("wr_word", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0, 32'd0);
        txn1("rd_word", 1'b0, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("mem_data_hold", bus1.mem_data_o, 32'hDEAD_BEEF);
        txn1("wr_byte", 1'b1, 1'b1, 32'h21, 32'h0000_0080, 2'b01, 1'b0, 1'b0, 32'd0);
        txn1("rd_byte_s", 1'b0, 1'b0, 32'h21, 32'd0, 2'b01, 1'b0, 1'b0, 32'hFFFF_FF80);
        txn1("rd_byte_u", 1'b1, 1'b0, 32'h21, 32'd0, 2'b01, 1'b1, 1'b0, 32'h0000_0080);
        txn1("wr_half_top", 1'b1, 1'b1, 32'h3FE, 32'h0000_8001, 2'b10, 1'b0, 1'b0, 32'd0);
        txn1("rd_half_top", 1'b0, 1'b0, 32'h3FE, 32'd0, 2'b10, 1'b0, 1'b0, 32'hFFFF_8001);
        txn1("wr_word_top", 1'b1, 1'b1, 32'h3FC, 32'hCAFE_F00D, 2'b11, 1'b0, 1'b0, 32'd0);
        txn1("rd_word_top", 1'b0, 1'b0, 32'h3FC, 32'd0, 2'b11, 1'b0, 1'b0, 32'hCAFE_F00D);

        txn1("err_half_odd", 1'b0, 1'b0, 32'h13, 32'd0, 2'b10, 1'b0, 1'b1, 32'd0);
        txn1("err_num0", 1'b1, 1'b1, 32'h0, 32'h1111_1111, 2'b00, 1'b0, 1'b1, 32'd0);
        txn1("err_word_3fe", 1'b0, 1'b0, 32'h3FE, 32'd0, 2'b11, 1'b0, 1'b1, 32'd0);
        txn1("err_word_400", 1'b1, 1'b0, 32'h400, 32'd0, 2'b11, 1'b0, 1'b1, 32'd0);
        txn1("err_byte_400", 1'b0, 1'b1, 32'h400, 32'h55, 2'b01, 1'b0, 1'b1, 32'd0);
        txn1("err_wrap", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 2'b11, 1'b0, 1'b1, 32'd0);
        txn1("rd_after_err", 1'b0, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Fairness: both requesters held from reset.
        rst1 = 1'b0;
        load1(1'b0, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0);
        load1(1'b1, 1'b0, 32'h3FC, 32'd0, 2'b11, 1'b0);
        bus1.req_i = 2'b11;
        tick(); tick();
        check("rr.rst_gnt", 32'(bus1.gnt_o), 32'd0);
        rst1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_oh;
            logic [31:0] exp_d;
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
            tick();
            check("rr.gnt", 32'(bus1.gnt_o), 32'(exp_oh));
            tick();
            check("rr.gnt_off", 32'(bus1.gnt_o), 32'd0);
            tick();
            check("rr.rvalid", 32'(bus1.rvalid_o), 32'(exp_oh));
            check("rr.rdata", bus1.rdata_o, exp_d);
        end
        clear1();

        // RD_LAT=4: full read by requester 1.
        bus4.we_i = 2'b00; bus4.addr1_i = 32'h8; bus4.req_i = 2'b10;
        tick();
        check("l4.gnt", 32'(bus4.gnt_o), 32'h2);
        bus4.req_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("l4.mem_read", 32'(bus4.mem_read_o), 32'd1);
            check("l4.no_rvalid", 32'(bus4.rvalid_o), 32'd0);
        end
        tick();
        check("l4.rvalid", 32'(bus4.rvalid_o), 32'h2);
        check("l4.rdata", bus4.rdata_o, 32'h1234_5678);
        check("l4.read_off", 32'(bus4.mem_read_o), 32'd0);

        // Requester 0 write moves the pointer to 1.
        bus4.we_i = 2'b01; bus4.addr0_i = 32'h0; bus4.wdata0_i = 32'h5A5A_5A5A; bus4.req_i = 2'b01;
        tick();
        check("l4w.gnt", 32'(bus4.gnt_o), 32'h1);
        bus4.req_i = 2'b00;
        tick();
        check("l4w.mem_write", 32'(bus4.mem_write_o), 32'd1);
        tick();
        check("l4w.rvalid", 32'(bus4.rvalid_o), 32'h1);

        // Reset during a read: no response, pointer back to 0.
        bus4.we_i = 2'b00; bus4.addr0_i = 32'h4; bus4.req_i = 2'b01;
        tick();
        check("mid.gnt", 32'(bus4.gnt_o), 32'h1);
        bus4.req_i = 2'b00;
        tick();
        check("mid.mem_read", 32'(bus4.mem_read_o), 32'd1);
        rst4 = 1'b0;
        tick();
        check("mid.read_dropped", 32'(bus4.mem_read_o), 32'd0);
        check("mid.rvalid_rst", 32'(bus4.rvalid_o), 32'd0);
        rst4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid.no_rvalid", 32'(bus4.rvalid_o), 32'd0);
            check("mid.no_read", 32'(bus4.mem_read_o), 32'd0);
        end
        bus4.we_i = 2'b00; bus4.req_i = 2'b11;
        tick();
        check("mid.ptr0_gnt", 32'(bus4.gnt_o), 32'h1);
        bus4.req_i = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check("mid.final_rvalid", 32'(bus4.rvalid_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
